// File: rtl/sw_packet_parser_if.sv
// sw_packet_parser_if
//   Bundles the frame-byte input stream and every parser output into one
//   interface so the parser can be dropped into a design as a single port.
//
//   master : the byte source / consumer side (drives data_in, sw_enable_in,
//            observes all parser outputs)
//   slave  : the parser itself (consumes the byte stream, drives header
//            fields, payload stream, completion pulses and counters)
//
//   Signals
//     data_in       DATA_W  frame byte
//     sw_enable_in  1       byte on data_in is consumed only when high
//     read_out      1       frame in progress
//     da, sa, len   DATA_W  captured header fields
//     hdr_valid     1       header accepted pulse
//     data_out      DATA_W  payload byte
//     data_valid    1       payload byte pulse
//     pkt_done      1       good frame pulse
//     pkt_err       1       bad frame pulse
//     err_code      2       1=parity, 2=EOF mismatch, 3=length too large
//     good_cnt      CNT_W   saturating good frame count
//     bad_cnt       CNT_W   saturating bad frame count
interface sw_packet_parser_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] data_in;
  logic              sw_enable_in;
  logic              read_out;
  logic [DATA_W-1:0] da;
  logic [DATA_W-1:0] sa;
  logic [DATA_W-1:0] len;
  logic              hdr_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              pkt_done;
  logic              pkt_err;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  good_cnt;
  logic [CNT_W-1:0]  bad_cnt;

  modport master (
    output data_in, sw_enable_in,
    input  read_out, da, sa, len, hdr_valid, data_out, data_valid,
           pkt_done, pkt_err, err_code, good_cnt, bad_cnt
  );

  modport slave (
    input  data_in, sw_enable_in,
    output read_out, da, sa, len, hdr_valid, data_out, data_valid,
           pkt_done, pkt_err, err_code, good_cnt, bad_cnt
  );
endinterface

// File: rtl/sw_packet_parser.sv
// sw_packet_parser
//   Byte-serial frame parser. Frame format:
//     SOF, DA, SA, LEN, LEN payload bytes, PARITY, EOF
//   PARITY is the XOR of DA, SA, LEN and all payload bytes.
//   Bytes are consumed only on cycles with sw_enable_in high; any other
//   cycle is a stall that freezes all parsing state.
//
//   Ports
//     clock   rising-edge clock
//     reset   asynchronous active-high reset; aborts any frame silently
//     bus     sw_packet_parser_if.slave (see interface for signal list)
//
//   All outputs are registered. Completion pulses (hdr_valid, data_valid,
//   pkt_done, pkt_err) appear the cycle after the byte that causes them.
module sw_packet_parser #(
  parameter int                DATA_W   = 8,
  parameter int                MAX_LEN  = 64,
  parameter logic [DATA_W-1:0] SOF_BYTE = DATA_W'(8'h55),
  parameter logic [DATA_W-1:0] EOF_BYTE = DATA_W'(8'hAA),
  parameter int                CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  sw_packet_parser_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    DA,
    SA,
    LEN,
    PAYLOAD,
    PARITY,
    EOF,
    DROP
  } state_t;

  // One extra bit so a MAX_LEN equal to the all-ones byte still compares
  // correctly against the incoming length byte.
  localparam logic [DATA_W:0] MAX_LEN_X = (DATA_W+1)'(MAX_LEN);

  state_t            state;
  logic [DATA_W-1:0] remain;     // payload bytes still to come
  logic [DATA_W-1:0] parity;     // running XOR since SOF
  logic              par_flag;   // sticky parity mismatch for this frame

  logic              en;
  logic [DATA_W-1:0] din;

  assign en  = bus.sw_enable_in;
  assign din = bus.data_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      remain         <= '0;
      parity         <= '0;
      par_flag       <= 1'b0;
      bus.read_out   <= 1'b0;
      bus.da         <= '0;
      bus.sa         <= '0;
      bus.len        <= '0;
      bus.hdr_valid  <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.pkt_done   <= 1'b0;
      bus.pkt_err    <= 1'b0;
      bus.err_code   <= 2'd0;
      bus.good_cnt   <= '0;
      bus.bad_cnt    <= '0;
    end else begin
      // Pulses last exactly one cycle.
      bus.hdr_valid  <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.pkt_done   <= 1'b0;
      bus.pkt_err    <= 1'b0;
      bus.err_code   <= 2'd0;

      // In IDLE, read_out is high only for the completion-pulse cycle that
      // follows an EOF; it drops afterwards unless a new SOF arrives now.
      if (state == IDLE) begin
        bus.read_out <= 1'b0;
      end

      if (en) begin
        unique case (state)
          IDLE: begin
            if (din == SOF_BYTE) begin
              state        <= DA;
              parity       <= '0;
              par_flag     <= 1'b0;
              bus.read_out <= 1'b1;
            end
          end

          DA: begin
            bus.da <= din;
            parity <= parity ^ din;
            state  <= SA;
          end

          SA: begin
            bus.sa <= din;
            parity <= parity ^ din;
            state  <= LEN;
          end

          LEN: begin
            bus.len <= din;
            parity  <= parity ^ din;
            remain  <= din;
            if (din == '0) begin
              state <= PARITY;
            end else if ({1'b0, din} > MAX_LEN_X) begin
              state        <= DROP;
              bus.pkt_err  <= 1'b1;
              bus.err_code <= 2'd3;
              if (bus.bad_cnt != '1) begin
                bus.bad_cnt <= bus.bad_cnt + CNT_W'(1);
              end
            end else begin
              state         <= PAYLOAD;
              bus.hdr_valid <= 1'b1;
            end
          end

          PAYLOAD: begin
            bus.data_out   <= din;
            bus.data_valid <= 1'b1;
            parity         <= parity ^ din;
            if (remain == DATA_W'(1)) begin
              state <= PARITY;
            end else begin
              remain <= remain - DATA_W'(1);
            end
          end

          PARITY: begin
            if (din != parity) begin
              par_flag <= 1'b1;
            end
            state <= EOF;
          end

          EOF: begin
            // read_out stays high through the pulse cycle; IDLE clears it.
            state <= IDLE;
            if (din == EOF_BYTE && !par_flag) begin
              bus.pkt_done <= 1'b1;
              if (bus.good_cnt != '1) begin
                bus.good_cnt <= bus.good_cnt + CNT_W'(1);
              end
            end else begin
              bus.pkt_err  <= 1'b1;
              // A bad terminator outranks a parity mismatch.
              bus.err_code <= (din != EOF_BYTE) ? 2'd2 : 2'd1;
              if (bus.bad_cnt != '1) begin
                bus.bad_cnt <= bus.bad_cnt + CNT_W'(1);
              end
            end
          end

          DROP: begin
            if (din == EOF_BYTE) begin
              state        <= IDLE;
              bus.read_out <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sw_packet_parser.sv
// tb_sw_packet_parser
//   Directed frames are driven by the stimulus process, which pushes the
//   expected header, payload and completion events into queues. A monitor
//   sampling on the falling edge pops and compares whenever the parser
//   pulses an output. Counters are 2 bits wide here so saturation is reached.
module tb_sw_packet_parser;

  logic clock = 1'b0;
  logic reset;
  logic end_req;

  always #5 clock = ~clock;

  sw_packet_parser_if #(.DATA_W(8), .CNT_W(2)) bus ();

  sw_packet_parser #(
    .DATA_W   (8),
    .MAX_LEN  (64),
    .SOF_BYTE (8'h55),
    .EOF_BYTE (8'hAA),
    .CNT_W    (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       done;
    logic       err;
    logic [1:0] code;
    logic [1:0] good;
    logic [1:0] bad;
  } end_t;

  logic [23:0] hq[$];
  logic [7:0]  dq[$];
  end_t        eq[$];

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] pay [64];
  logic [1:0] exp_good = 2'd0;
  logic [1:0] exp_bad  = 2'd0;

  localparam int unsigned NO_STALL = 999;

  // ---------------- monitor / scoreboard ----------------
  logic [23:0] h_exp;
  logic [7:0]  d_exp;
  end_t        e_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      check("reset_state",
            {bus.read_out, bus.da, bus.sa, bus.len, bus.hdr_valid, bus.data_out,
             bus.data_valid, bus.pkt_done, bus.pkt_err, bus.err_code,
             bus.good_cnt, bus.bad_cnt}, 64'd0);
    end else begin
      if (bus.hdr_valid) begin
        if (hq.size() == 0) begin
          check("hdr_unexpected", 64'd1, 64'd0);
        end else begin
          h_exp = hq.pop_front();
          check("hdr_fields", {bus.da, bus.sa, bus.len}, h_exp);
        end
      end
      if (bus.data_valid) begin
        if (dq.size() == 0) begin
          check("data_unexpected", 64'd1, 64'd0);
        end else begin
          d_exp = dq.pop_front();
          check("data_out", bus.data_out, d_exp);
        end
      end
      if (bus.pkt_done || bus.pkt_err) begin
        if (eq.size() == 0) begin
          check("end_unexpected", {bus.pkt_done, bus.pkt_err, bus.err_code}, 64'd0);
        end else begin
          e_exp = eq.pop_front();
          check("end_event {done,err,code,good,bad}",
                {bus.pkt_done, bus.pkt_err, bus.err_code, bus.good_cnt, bus.bad_cnt},
                e_exp);
          check("read_out_at_end", bus.read_out, 64'd1);
        end
      end
      if (end_req) begin
        check("leftover_expected_events", hq.size() + dq.size() + eq.size(), 64'd0);
        check("idle_read_out", bus.read_out, 64'd0);
        check("final_counters", {bus.good_cnt, bus.bad_cnt}, {exp_good, exp_bad});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    bus.data_in      = b;
    bus.sw_enable_in = 1'b1;
    @(posedge clock);
    #1;
    bus.sw_enable_in = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    bus.sw_enable_in = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_end(input logic done, input logic [1:0] code);
    end_t e;
    if (done) exp_good = (exp_good == 2'd3) ? 2'd3 : exp_good + 2'd1;
    else      exp_bad  = (exp_bad  == 2'd3) ? 2'd3 : exp_bad  + 2'd1;
    e.done = done;
    e.err  = !done;
    e.code = code;
    e.good = exp_good;
    e.bad  = exp_bad;
    eq.push_back(e);
  endtask

  // Legal-length frame; payload taken from pay[0 .. l-1].
  task automatic send_frame(input logic [7:0] d, input logic [7:0] s, input logic [7:0] l,
                            input logic [7:0] pdelta, input logic [7:0] eofb,
                            input int unsigned stall_at, input int unsigned stall_n);
    logic [7:0] p;
    p = d ^ s ^ l;
    for (int unsigned i = 0; i < l; i++) p = p ^ pay[i];
    if (l != 8'd0) hq.push_back({d, s, l});
    send(8'h55);
    send(d);
    send(s);
    send(l);
    for (int unsigned i = 0; i < l; i++) begin
      if (i == stall_at) idle(stall_n);
      dq.push_back(pay[i]);
      send(pay[i]);
    end
    if (eofb != 8'hAA)       push_end(1'b0, 2'd2);
    else if (pdelta != 8'd0) push_end(1'b0, 2'd1);
    else                     push_end(1'b1, 2'd0);
    send(p ^ pdelta);
    send(eofb);
  endtask

  initial begin
    reset            = 1'b1;
    end_req          = 1'b0;
    bus.sw_enable_in = 1'b0;
    bus.data_in      = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Non-SOF bytes in IDLE produce nothing.
    send(8'h12);
    send(8'hAA);
    send(8'h00);
    idle(2);

    // 55,01,02,03,A0,B1,C2,D3,AA : good frame (parity 01^02^03^A0^B1^C2 = D3)
    pay[0] = 8'hA0; pay[1] = 8'hB1; pay[2] = 8'hC2;
    send_frame(8'h01, 8'h02, 8'h03, 8'h00, 8'hAA, NO_STALL, 0);
    // Same frame, parity byte off by one bit -> code 1
    send_frame(8'h01, 8'h02, 8'h03, 8'h01, 8'hAA, NO_STALL, 0);

    // Length 65 > 64 -> code 3, then bytes ignored (including a stray SOF) until AA
    send(8'h55);
    send(8'h01);
    send(8'h02);
    push_end(1'b0, 2'd3);
    send(8'h41);
    send(8'h55);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'hA0);
    idle(2);
    send(8'hAA);
    idle(1);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00, 8'hAA, NO_STALL, 0);

    // Length exactly 64 is legal
    for (int unsigned i = 0; i < 64; i++) pay[i] = 8'(i * 7 + 3);
    send_frame(8'h10, 8'h20, 8'h40, 8'h00, 8'hAA, NO_STALL, 0);

    // Back-to-back frames, 3-cycle stall mid-payload in the first; good_cnt saturates
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44; pay[4] = 8'h5A;
    send_frame(8'h0A, 8'h0B, 8'h05, 8'h00, 8'hAA, $urandom_range(1, 4), 3);
    send_frame(8'h0C, 8'h0D, 8'h05, 8'h00, 8'hAA, NO_STALL, 0);

    // Len=0: 55,01,02,00,03,AA good; then EOF byte 00 -> code 2
    send_frame(8'h01, 8'h02, 8'h00, 8'h00, 8'hAA, NO_STALL, 0);
    send_frame(8'h01, 8'h02, 8'h00, 8'h00, 8'h00, NO_STALL, 0);

    // Parity error and bad EOF together -> code 2; bad_cnt saturates
    pay[0] = 8'hA0; pay[1] = 8'hB1; pay[2] = 8'hC2;
    send_frame(8'h01, 8'h02, 8'h03, 8'h01, 8'h00, NO_STALL, 0);
    idle(2);

    // Reset during payload aborts silently and clears counters
    hq.push_back({8'h01, 8'h02, 8'h03});
    send(8'h55);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    dq.push_back(8'hA0);
    send(8'hA0);
    @(negedge clock);
    #1 reset = 1'b1;
    exp_good = 2'd0;
    exp_bad  = 2'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    send_frame(8'h01, 8'h02, 8'h03, 8'h00, 8'hAA, NO_STALL, 0);

    idle(5);
    end_req = 1'b1;
    repeat (5) @(posedge clock);
    $display("FAIL end_of_run: monitor did not reach summary");
    $fatal(1);
  end

endmodule
